mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single 8-bit synchronous RAM between two requesters: port 0 (CPU memory path) and
//  port 1 (program loader / DMA). Round-robin arbitration, req/ack handshake, optional bus lock
//  for bursts with bounded hold. Sits between the requesters and the RAM; all RAM strobes come from here.
// PARAMETERS
//  AW        8   address width (bits)
//  DW        8   data width (bits)
//  MAX_LOCK  4   max consecutive locked accesses by one port while the other port is requesting (>=1)
// PORTS
//  clk         in   1   system clock; all state on posedge
//  reset       in   1   asynchronous, active-high reset
//  req0/req1   in   1   access request; held with addr/we/wdata/lock stable until ack
//  lock0/lock1 in   1   keep ownership after this access (burst)
//  we0/we1     in   1   1 = write, 0 = read
//  addr0/addr1 in   AW  access address
//  wdata0/wdata1 in DW  write data
//  ack0/ack1   out  1   one-cycle completion pulse
//  rdata0/rdata1 out DW read data; valid while ack is high, held until that port's next read ack
//  mem_addr    out  AW  RAM address
//  mem_wdata   out  DW  RAM write data
//  mem_we      out  1   RAM write strobe (one cycle)
//  mem_re      out  1   RAM read strobe (one cycle); mem_rdata valid the following cycle
//  mem_rdata   in   DW  RAM read data
//  busy        out  1   high in ISSUE and DONE
//  owner       out  1   port currently or last granted
//  grant_cnt0/grant_cnt1 out 8 completed accesses per port (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; all ack*, mem_we, mem_re, busy = 0; mem_addr, mem_wdata, rdata* = 0;
//    owner=1 (so port 0 wins the first tie); lock_cnt=0; grant counters = 0. Reset mid-access aborts it: no ack, no strobe.
//  - FSM IDLE -> ISSUE -> DONE -> IDLE; exactly 3 cycles per access, request sampled in IDLE.
//  - IDLE: no req -> stay. One req -> grant it. Both -> grant !owner (round-robin), except lock rule.
//    Latch winner's addr/we/wdata into mem_addr/mem_wdata; owner<=winner.
//  - ISSUE: mem_we=we or mem_re=!we for exactly this cycle.
//  - DONE: ack<owner>=1 for one cycle; on read, rdata<owner> <= mem_rdata registered to be valid in DONE.
//    Requester must drop or replace req at the edge ending DONE; IDLE sees the new value.
//  - Lock: if lock<owner> was 1 at grant, next IDLE grants owner again if it requests,
//    ignoring round-robin. lock_cnt counts consecutive locked grants while other port requests;
//    at lock_cnt==MAX_LOCK the other port wins the next tie and lock_cnt clears.
//    lock_cnt clears whenever the other port is idle or ownership changes.
//  - Locked owner not requesting in IDLE: lock is released, normal arbitration.
//  - Requester dropping req before ack (protocol violation): the in-flight access completes; ack still pulses.
//  - Only one of ack0/ack1 ever high; mem_we and mem_re never high together.
//  - Address/data are passed unchanged; no wrap logic (AW-bit address space).
// CONFIGURATION
//  MEM_ARB_STATS_EN defined: grant_cnt0/1 increment on each ack of that port, saturating at 8'hFF.
//  Not defined: grant_cnt0/1 tied to 0, no counter flops; all other behaviour identical.
// TESTING
//  1 reset, req0=1 we0=0 addr0=8'h10, RAM[10]=8'hA5 -> mem_re high cycle 2, ack0 + rdata0=8'hA5 cycle 3.
//  2 req1 write addr1=8'h20 wdata1=8'h3C -> single mem_we pulse with mem_addr=20/mem_wdata=3C; ack1 next cycle; RAM[20]=3C.
//  3 req0 and req1 held continuously, no lock -> acks alternate 0,1,0,1 every 3 cycles, port 0 first.
//  4 lock1=1 with req0 held, MAX_LOCK=4 -> four port-1 grants, then port 0 granted.
//  5 assert reset during ISSUE -> mem_re/mem_we drop at once, no ack, owner=1, next access starts from IDLE.
//  6 with MEM_ARB_STATS_EN, 300 port-0 accesses -> grant_cnt0=8'hFF, grant_cnt1 unchanged; without it both read 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port RAM arbiter with burst lock; define MEM_ARB_STATS_EN for grant counters
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner,
  output logic [7:0]    grant_cnt0,
  output logic [7:0]    grant_cnt1
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_n;
  logic locked, we_q, hold, force_sw, win, win_lock, win_oreq, grant;
  logic [LW-1:0] lock_cnt, cnt_n;
  logic [DW-1:0] rdata0_q, rdata1_q;
  // state register; async reset aborts any in-flight access
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // fixed three-cycle access sequence, started only from IDLE with a request
  always_comb
    state_n = state == IDLE ? ((req0 || req1) ? ISSUE : IDLE) : state == ISSUE ? DONE : IDLE;
  // winner selection: held lock beats round-robin until the other port has waited MAX_LOCK grants
  always_comb begin
    hold     = locked && (owner ? req1 : req0);
    force_sw = hold && (owner ? req0 : req1) && lock_cnt == LW'(MAX_LOCK);
    win      = force_sw ? ~owner : hold ? owner : (req0 && req1) ? ~owner : req1;
    win_lock = win ? lock1 : lock0;
    win_oreq = win ? req0 : req1;
    cnt_n    = (force_sw || !(win_lock && win_oreq)) ? '0 : hold ? lock_cnt + 1'b1 : LW'(1);
    grant    = state == IDLE && (req0 || req1);
  end
  // latch the winner's access at grant and capture read data as the access completes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner     <= 1'b1;
      locked    <= 1'b0;
      lock_cnt  <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else if (grant) begin
      owner     <= win;
      locked    <= win_lock;
      lock_cnt  <= cnt_n;
      we_q      <= win ? we1 : we0;
      mem_addr  <= win ? addr1 : addr0;
      mem_wdata <= win ? wdata1 : wdata0;
    end else if (state == DONE && !we_q) begin
      if (owner) rdata1_q <= mem_rdata;
      else rdata0_q <= mem_rdata;
    end
  // strobes and acks decoded from state so reset removes them immediately
  always_comb begin
    busy   = state != IDLE;
    mem_we = state == ISSUE && we_q;
    mem_re = state == ISSUE && !we_q;
    ack0   = state == DONE && !owner;
    ack1   = state == DONE && owner;
    rdata0 = (ack0 && !we_q) ? mem_rdata : rdata0_q;
    rdata1 = (ack1 && !we_q) ? mem_rdata : rdata1_q;
  end
`ifdef MEM_ARB_STATS_EN
  // saturating per-port completion counters
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (ack0 && grant_cnt0 != 8'hFF) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (ack1 && grant_cnt1 != 8'hFF) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural RAM
module tb_mem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, mem_we, mem_re, busy, owner;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata, grant_cnt0, grant_cnt1;
  logic [7:0] ram [256];
  int pass_cnt = 0, chk_cnt = 0;
`ifdef MEM_ARB_STATS_EN
  localparam logic [7:0] CNT0_FULL = 8'hFF;
`else
  localparam logic [7:0] CNT0_FULL = 8'h00;
`endif

  mem_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ram[8'h10] <= 8'hA5;
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  initial begin
    int acks, clash;
    logic [5:0] seq;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_strobes", {mem_we, mem_re}, 0);
    check("rst_owner", owner, 1);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);
    check("rst_cnts", {grant_cnt0, grant_cnt1}, 0);
    reset = 0;
    // single read on port 0
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 8'h10;
    @(negedge clk);
    check("t1_issue", {mem_re, mem_we, busy}, 3'b101);
    check("t1_addr", mem_addr, 8'h10);
    @(negedge clk);
    check("t1_ack", {ack0, ack1}, 2'b10);
    check("t1_rdata", rdata0, 8'hA5);
    req0 = 0;
    @(negedge clk);
    check("t1_idle", {ack0, busy}, 0);
    check("t1_hold", rdata0, 8'hA5);
    // single write on port 1
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
    @(negedge clk);
    check("t2_issue", {mem_we, mem_re, mem_addr, mem_wdata}, {2'b10, 8'h20, 8'h3C});
    check("t2_owner", owner, 1);
    @(negedge clk);
    check("t2_ack", {ack1, ack0, mem_we}, 3'b100);
    req1 = 0; we1 = 0;
    @(negedge clk);
    check("t2_ram", ram[8'h20], 8'h3C);
    // both requesting continuously, no lock
    req0 = 1; req1 = 1; seq = 0; acks = 0; clash = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((ack0 && ack1) || (mem_we && mem_re)) clash++;
      if (ack0 || ack1) begin seq = {seq[4:0], ack1}; acks++; end
    end
    req0 = 0; req1 = 0;
    check("t3_count", acks, 4);
    check("t3_order", seq[3:0], 4'b0101);
    // port 1 locked with port 0 waiting
    @(negedge clk);
    req0 = 1; req1 = 1; lock1 = 1; seq = 0; acks = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if ((ack0 && ack1) || (mem_we && mem_re)) clash++;
      if (ack0 || ack1) begin seq = {seq[4:0], ack1}; acks++; end
    end
    req0 = 0; req1 = 0; lock1 = 0;
    check("t4_count", acks, 6);
    check("t4_order", seq, 6'b011110);
    check("exclusive", clash, 0);
    // reset during ISSUE
    @(negedge clk);
    req0 = 1; addr0 = 8'h10;
    @(negedge clk);
    check("t5_pre", mem_re, 1);
    #2 reset = 1; req0 = 0;
    #1 check("t5_drop", {mem_re, mem_we, busy, ack0, ack1}, 0);
    check("t5_owner", owner, 1);
    @(negedge clk);
    reset = 0; acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) acks++;
    end
    check("t5_noack", acks, 0);
    req0 = 1; addr0 = 8'h20;
    repeat (2) @(negedge clk);
    check("t5_restart", {ack0, rdata0}, {1'b1, 8'h3C});
    req0 = 0;
    @(negedge clk);
    // 300 port-0 accesses for the counters
    req0 = 1; addr0 = 8'h10; acks = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    req0 = 0;
    check("t6_acks", acks, 300);
    check("t6_cnt0", grant_cnt0, CNT0_FULL);
    check("t6_cnt1", grant_cnt1, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
